jtag_ir_gen2: RTL and testbench

JTAG_IR_GEN2 -- requirements
Module: jtag_ir_gen2

---
 rtl/jtag_types_pkg.sv | 27 ++
 rtl/jtag_ir_decode.sv | 46 ++++
 rtl/jtag_ir_gen2.sv | 141 ++++++++++++++
 tb/tb_jtag_ir_gen2.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_types_pkg.sv
// Shared types and default opcode values for the JTAG instruction register.
package jtag_types_pkg;

  // Which test data register the current instruction selects.
  typedef enum logic [2:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_SAMPLE,
    SEL_EXTEST,
    SEL_PRIVATE
  } instr_sel_t;

  // Default instruction length and opcode values.
  // The width-dependent opcodes are resized by the modules that use them.
  localparam int DEF_IR_WIDTH  = 5;
  localparam int DEF_OP_EXTEST = 0;
  localparam int DEF_OP_SAMPLE = 1;
  localparam int DEF_OP_IDCODE = 2;
  localparam int DEF_PRIV_LO   = 16;
  localparam int DEF_PRIV_HI   = 30;

  // Inclusive range test for the private opcode window.
  function automatic logic in_priv(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/jtag_ir_decode.sv
// Combinational instruction decode.
// Produces the selected data register as an enum and as one-hot strobes.
// Unknown non-private opcodes fall back to BYPASS.
module jtag_ir_decode
  import jtag_types_pkg::*;
#(
  parameter int                  IR_WIDTH  = DEF_IR_WIDTH,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(DEF_OP_EXTEST),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(DEF_OP_SAMPLE),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(DEF_OP_IDCODE),
  parameter int                  PRIV_LO   = DEF_PRIV_LO,
  parameter int                  PRIV_HI   = DEF_PRIV_HI
) (
  input  logic [IR_WIDTH-1:0] instr,
  output instr_sel_t          sel,
  output logic                sel_bypass,
  output logic                sel_idcode,
  output logic                sel_sample,
  output logic                sel_extest,
  output logic                sel_private
);

  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

  // Priority decode:
  //   1. all-ones always means BYPASS
  //   2. the public opcodes
  //   3. the private window
  //   4. anything else selects BYPASS
  always_comb begin
    sel = SEL_BYPASS;
    if (instr == OP_BYPASS)                      sel = SEL_BYPASS;
    else if (instr == OP_IDCODE)                 sel = SEL_IDCODE;
    else if (instr == OP_SAMPLE)                 sel = SEL_SAMPLE;
    else if (instr == OP_EXTEST)                 sel = SEL_EXTEST;
    else if (in_priv(32'(instr), PRIV_LO, PRIV_HI)) sel = SEL_PRIVATE;
  end

  // One-hot strobes follow directly from the enum, so exactly one is ever high.
  assign sel_bypass  = (sel == SEL_BYPASS);
  assign sel_idcode  = (sel == SEL_IDCODE);
  assign sel_sample  = (sel == SEL_SAMPLE);
  assign sel_extest  = (sel == SEL_EXTEST);
  assign sel_private = (sel == SEL_PRIVATE);

endmodule

// File: rtl/jtag_ir_gen2.sv
// JTAG instruction register.
//   - Capture and shift happen on the TCK posedge.
//   - Update happens on the TCK negedge.
//   - Optional length checking on update.
//   - Private opcodes can be gated by priv_unlock.
//   - Sticky error flags record short shifts and denied private opcodes.
module jtag_ir_gen2
  import jtag_types_pkg::*;
#(
  parameter int                  IR_WIDTH   = DEF_IR_WIDTH,
  parameter int                  STRICT_LEN = 0,
  parameter int                  HAS_IDCODE = 1,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(DEF_OP_EXTEST),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(DEF_OP_SAMPLE),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(DEF_OP_IDCODE),
  parameter int                  PRIV_LO    = DEF_PRIV_LO,
  parameter int                  PRIV_HI    = DEF_PRIV_HI
) (
  input  logic                                      TCK,
  input  logic                                      TRST,
  input  logic                                      TDI,
  output logic                                      TDO,
  input  logic                                      ir_capture,
  input  logic                                      ir_shift,
  input  logic                                      ir_update,
  input  logic                                      tlr_reset,
  input  logic [((IR_WIDTH > 2) ? IR_WIDTH-2 : 1)-1:0] capture_status,
  input  logic                                      priv_unlock,
  input  logic                                      len_err_clr,
  output logic [IR_WIDTH-1:0]                       instr_out,
  output instr_sel_t                                instr_sel,
  output logic                                      sel_bypass,
  output logic                                      sel_idcode,
  output logic                                      sel_sample,
  output logic                                      sel_extest,
  output logic                                      sel_private,
  output logic                                      len_err,
  output logic                                      priv_denied
);

  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
  localparam logic [IR_WIDTH-1:0] RST_INSTR = (HAS_IDCODE != 0) ? OP_IDCODE : OP_BYPASS;
  localparam int                  CW        = $clog2(IR_WIDTH + 1);
  localparam logic [CW-1:0]       CNT_MAX   = CW'(IR_WIDTH);

  logic [IR_WIDTH-1:0] shift_reg;
  logic [IR_WIDTH-1:0] cap_val;
  logic [CW-1:0]       shift_cnt;

  // Each sticky flag is set on the negedge (update) and cleared on the posedge.
  // A pair of toggle flops, one per edge domain, implements this without a
  // multiply-driven register. The flag is high while the two toggles differ.
  logic len_set_tog, len_clr_tog;
  logic pd_set_tog,  pd_clr_tog;

  // Capture value: design status sits above the mandatory 01 pattern.
  // A 2-bit IR has no room for status.
  if (IR_WIDTH > 2) begin : g_cap_status
    assign cap_val = {capture_status, 2'b01};
  end else begin : g_cap_fixed
    assign cap_val = IR_WIDTH'(2'b01);
  end

  assign TDO = shift_reg[0];

  // Shift path.
  //   - Test-logic-reset overrides everything.
  //   - Capture beats shift.
  //   - The shift counter saturates at IR_WIDTH.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      shift_reg <= OP_BYPASS;
      shift_cnt <= '0;
    end else if (tlr_reset) begin
      shift_reg <= OP_BYPASS;
      shift_cnt <= '0;
    end else if (ir_capture) begin
      shift_reg <= cap_val;
      shift_cnt <= '0;
    end else if (ir_shift) begin
      shift_reg <= {TDI, shift_reg[IR_WIDTH-1:1]};
      if (shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + 1'b1;
    end
  end

  // Clear side of the sticky flags: snap each clear toggle to its set toggle.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      len_clr_tog <= 1'b0;
      pd_clr_tog  <= 1'b0;
    end else if (len_err_clr) begin
      len_clr_tog <= len_set_tog;
      pd_clr_tog  <= pd_set_tog;
    end
  end

  // Update path. Possible outcomes:
  //   - a short shift is rejected (strict mode only);
  //   - a locked private opcode is replaced by BYPASS;
  //   - otherwise the shifted opcode is loaded.
  // Setting a flag forces its set toggle away from the clear toggle.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      instr_out   <= RST_INSTR;
      len_set_tog <= 1'b0;
      pd_set_tog  <= 1'b0;
    end else if (tlr_reset) begin
      instr_out <= RST_INSTR;
    end else if (ir_update) begin
      if ((STRICT_LEN != 0) && (shift_cnt < CNT_MAX)) begin
        len_set_tog <= ~len_clr_tog;
      end else if (in_priv(32'(shift_reg), PRIV_LO, PRIV_HI) && !priv_unlock) begin
        instr_out  <= OP_BYPASS;
        pd_set_tog <= ~pd_clr_tog;
      end else begin
        instr_out <= shift_reg;
      end
    end
  end

  assign len_err     = len_set_tog ^ len_clr_tog;
  assign priv_denied = pd_set_tog ^ pd_clr_tog;

  jtag_ir_decode #(
    .IR_WIDTH (IR_WIDTH),
    .OP_EXTEST(OP_EXTEST),
    .OP_SAMPLE(OP_SAMPLE),
    .OP_IDCODE(OP_IDCODE),
    .PRIV_LO  (PRIV_LO),
    .PRIV_HI  (PRIV_HI)
  ) u_decode (
    .instr      (instr_out),
    .sel        (instr_sel),
    .sel_bypass (sel_bypass),
    .sel_idcode (sel_idcode),
    .sel_sample (sel_sample),
    .sel_extest (sel_extest),
    .sel_private(sel_private)
  );

endmodule

// File: tb/tb_jtag_ir_gen2.sv
// Directed bench for jtag_ir_gen2.
// Two instances share stimulus:
//   - dut:   default, non-strict length checking
//   - dut_s: STRICT_LEN=1
module tb_jtag_ir_gen2;
  import jtag_types_pkg::*;

  logic       TCK = 1'b0, TRST = 1'b1, TDI = 1'b0;
  logic       ir_capture = 1'b0, ir_shift = 1'b0, ir_update = 1'b0, tlr_reset = 1'b0;
  logic       priv_unlock = 1'b0, len_err_clr = 1'b0;
  logic [2:0] capture_status = 3'b000;

  logic       TDO, sel_bypass, sel_idcode, sel_sample, sel_extest, sel_private, len_err, priv_denied;
  logic [4:0] instr_out;
  instr_sel_t instr_sel;

  logic       TDO_s, sel_bypass_s, sel_idcode_s, sel_sample_s, sel_extest_s, sel_private_s;
  logic       len_err_s, priv_denied_s;
  logic [4:0] instr_out_s;
  instr_sel_t instr_sel_s;

  jtag_ir_gen2 dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .TDO(TDO),
    .ir_capture(ir_capture), .ir_shift(ir_shift), .ir_update(ir_update), .tlr_reset(tlr_reset),
    .capture_status(capture_status), .priv_unlock(priv_unlock), .len_err_clr(len_err_clr),
    .instr_out(instr_out), .instr_sel(instr_sel),
    .sel_bypass(sel_bypass), .sel_idcode(sel_idcode), .sel_sample(sel_sample),
    .sel_extest(sel_extest), .sel_private(sel_private),
    .len_err(len_err), .priv_denied(priv_denied)
  );

  jtag_ir_gen2 #(.STRICT_LEN(1)) dut_s (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .TDO(TDO_s),
    .ir_capture(ir_capture), .ir_shift(ir_shift), .ir_update(ir_update), .tlr_reset(tlr_reset),
    .capture_status(capture_status), .priv_unlock(priv_unlock), .len_err_clr(len_err_clr),
    .instr_out(instr_out_s), .instr_sel(instr_sel_s),
    .sel_bypass(sel_bypass_s), .sel_idcode(sel_idcode_s), .sel_sample(sel_sample_s),
    .sel_extest(sel_extest_s), .sel_private(sel_private_s),
    .len_err(len_err_s), .priv_denied(priv_denied_s)
  );

  always #5 TCK = ~TCK;

  int checks = 0;
  int errors = 0;

  // Select bit order used by all expected values:
  //   {bypass, idcode, sample, extest, private}
  localparam logic [4:0] S_BYP = 5'b10000, S_ID = 5'b01000, S_SMP = 5'b00100,
                         S_EXT = 5'b00010, S_PRV = 5'b00001;

  typedef struct {
    logic [4:0] op;
    logic       unlock;
    logic [4:0] exp_instr;
    logic [4:0] exp_sel;
    logic       exp_priv;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] sels();
    return {sel_bypass, sel_idcode, sel_sample, sel_extest, sel_private};
  endfunction

  task automatic step();
    @(posedge TCK);
    #1;
  endtask

  // Capture (also clearing sticky flags), shift nshift bits of op LSB first,
  // then update on the following negedge. Returns 1ns after that negedge.
  task automatic load_op(input logic [4:0] op, input logic unlock, input int nshift);
    ir_capture  = 1'b1;
    len_err_clr = 1'b1;
    step();
    ir_capture  = 1'b0;
    len_err_clr = 1'b0;
    ir_shift    = 1'b1;
    for (int i = 0; i < nshift; i++) begin
      TDI = op[i];
      step();
    end
    ir_shift    = 1'b0;
    ir_update   = 1'b1;
    priv_unlock = unlock;
    @(negedge TCK);
    #1;
    ir_update = 1'b0;
  endtask

  initial begin
    logic [4:0] cap_exp;
    cap_exp = 5'b10101;

    vecs[0] = '{5'b00001, 1'b0, 5'b00001, S_SMP, 1'b0};
    vecs[1] = '{5'b00000, 1'b0, 5'b00000, S_EXT, 1'b0};
    vecs[2] = '{5'b00010, 1'b0, 5'b00010, S_ID,  1'b0};
    vecs[3] = '{5'b00111, 1'b0, 5'b00111, S_BYP, 1'b0};
    vecs[4] = '{5'b10000, 1'b0, 5'b11111, S_BYP, 1'b1};
    vecs[5] = '{5'b10000, 1'b1, 5'b10000, S_PRV, 1'b0};
    vecs[6] = '{5'b11110, 1'b0, 5'b11111, S_BYP, 1'b1};
    vecs[7] = '{5'b01111, 1'b0, 5'b01111, S_BYP, 1'b0};
    vecs[8] = '{5'b11111, 1'b0, 5'b11111, S_BYP, 1'b0};
    vecs[9] = '{5'b11110, 1'b1, 5'b11110, S_PRV, 1'b0};

    // Reset state
    #1 TRST = 1'b0;
    #2;
    chk("rst_instr",   16'(instr_out),   16'(5'b00010));
    chk("rst_sel",     16'(sels()),      16'(S_ID));
    chk("rst_enum",    16'(instr_sel),   16'(SEL_IDCODE));
    chk("rst_tdo",     16'(TDO),         16'd1);
    chk("rst_len_err", 16'(len_err),     16'd0);
    chk("rst_priv",    16'(priv_denied), 16'd0);
    @(negedge TCK);
    #1 TRST = 1'b1;

    // Capture pattern {101, 01} shifts out LSB first
    capture_status = 3'b101;
    ir_capture     = 1'b1;
    step();
    ir_capture = 1'b0;
    chk("cap_tdo0", 16'(TDO), 16'(cap_exp[0]));
    ir_shift = 1'b1;
    TDI      = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      chk($sformatf("cap_tdo%0d", i), 16'(TDO), 16'(cap_exp[i]));
    end
    ir_shift       = 1'b0;
    capture_status = 3'b000;

    // Table of opcodes through a full 5-bit shift and update
    foreach (vecs[k]) begin
      load_op(vecs[k].op, vecs[k].unlock, 5);
      chk($sformatf("v%0d_instr", k),   16'(instr_out),   16'(vecs[k].exp_instr));
      chk($sformatf("v%0d_sel", k),     16'(sels()),      16'(vecs[k].exp_sel));
      chk($sformatf("v%0d_priv", k),    16'(priv_denied), 16'(vecs[k].exp_priv));
      chk($sformatf("v%0d_s_instr", k), 16'(instr_out_s), 16'(vecs[k].exp_instr));
      chk($sformatf("v%0d_s_len", k),   16'(len_err_s),   16'd0);
    end
    priv_unlock = 1'b0;

    // Short shift: strict instance holds and flags; default accepts 00001>>3 = 00000
    load_op(5'b00001, 1'b0, 5);
    load_op(5'b11000, 1'b0, 3);
    chk("short_s_instr", 16'(instr_out_s), 16'(5'b00001));
    chk("short_s_len",   16'(len_err_s),   16'd1);
    chk("short_instr",   16'(instr_out),   16'(5'b00000));
    chk("short_sel",     16'(sels()),      16'(S_EXT));
    chk("short_len",     16'(len_err),     16'd0);
    step();
    chk("short_s_sticky", 16'(len_err_s), 16'd1);
    len_err_clr = 1'b1;
    step();
    len_err_clr = 1'b0;
    chk("short_s_clr", 16'(len_err_s), 16'd0);

    // Test-logic-reset during a shift, then an update without a new capture
    ir_capture = 1'b1;
    step();
    ir_capture = 1'b0;
    ir_shift   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      TDI = (i == 1);
      step();
    end
    chk("pre_tlr_tdo", 16'(TDO), 16'd0);
    tlr_reset = 1'b1;
    TDI       = 1'b0;
    step();
    chk("tlr_tdo", 16'(TDO), 16'd1);
    @(negedge TCK);
    #1;
    chk("tlr_instr",   16'(instr_out),   16'(5'b00010));
    chk("tlr_sel",     16'(sels()),      16'(S_ID));
    chk("tlr_s_instr", 16'(instr_out_s), 16'(5'b00010));
    tlr_reset = 1'b0;
    ir_shift  = 1'b0;
    ir_update = 1'b1;
    @(negedge TCK);
    #1;
    ir_update = 1'b0;
    chk("tlr_cnt0_s_len",   16'(len_err_s),   16'd1);
    chk("tlr_cnt0_s_instr", 16'(instr_out_s), 16'(5'b00010));
    chk("tlr_upd_instr",    16'(instr_out),   16'(5'b11111));
    chk("tlr_upd_sel",      16'(sels()),      16'(S_BYP));

    // Sticky flag survives test-logic-reset
    tlr_reset = 1'b1;
    step();
    @(negedge TCK);
    #1;
    tlr_reset = 1'b0;
    chk("tlr_keeps_len", 16'(len_err_s), 16'd1);

    // Asynchronous reset in the middle of a shift
    load_op(5'b00001, 1'b0, 5);
    ir_capture = 1'b1;
    step();
    ir_capture = 1'b0;
    ir_shift   = 1'b1;
    TDI        = 1'b0;
    step();
    step();
    TRST = 1'b0;
    #1;
    chk("mid_rst_instr", 16'(instr_out),   16'(5'b00010));
    chk("mid_rst_tdo",   16'(TDO),         16'd1);
    chk("mid_rst_s_len", 16'(len_err_s),   16'd0);
    chk("mid_rst_sel",   16'(sels()),      16'(S_ID));
    ir_shift = 1'b0;
    step();
    TRST = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
